reg_xfer_ctrl: RTL and testbench

Sequencer for the 6502 register-transfer and index-update group: TAX, TAY, TXA, TYA, TSX, TXS, INX, INY, DEX, DEY, LDA/LDX/LDY immediate. It accepts one operation at a time over a valid/ready handshake and reads the current A/X/Y/S values. It computes the result on the shared internal bus, strobes exactly one register load, and reports N/Z flags to the status logic. It sits between the instruction-decode FSM and the A/X/Y/S register modules.

---
 rtl/reg_xfer_ctrl.sv | 134 +++++++++++++
 tb/tb_reg_xfer_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_xfer_ctrl.sv
// rtl/reg_xfer_ctrl.sv - 6502 register-transfer / index-update sequencer (IDLE/SRC/WR/DONE)
// Optional flag logic is built when XFER_FLAGS_EN is defined.
module reg_xfer_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              FSM_Signal,
  input  logic              reset_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] op_imm,
  input  logic [DATA_W-1:0] A_in,
  input  logic [DATA_W-1:0] X_in,
  input  logic [DATA_W-1:0] Y_in,
  input  logic [DATA_W-1:0] S_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              load_A,
  output logic              load_X,
  output logic              load_Y,
  output logic              load_S,
  output logic              flag_N,
  output logic              flag_Z,
  output logic              flag_we,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, SRC, WR, DONE} state_t;

  state_t            state;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] res;
  logic [3:0]        dest;

  // DONE also takes a new op so back-to-back operations run one per 3 cycles.
  assign op_ready = (state == IDLE) || (state == DONE);

  // dest is one-hot {A, X, Y, S}; zero for NOP and illegal codes.
  always_comb begin
    res  = '0;
    dest = 4'b0000;
    case (op_q)
      4'd1:  begin res = A_in;                dest = 4'b0100; end
      4'd2:  begin res = A_in;                dest = 4'b0010; end
      4'd3:  begin res = X_in;                dest = 4'b1000; end
      4'd4:  begin res = Y_in;                dest = 4'b1000; end
      4'd5:  begin res = S_in;                dest = 4'b0100; end
      4'd6:  begin res = X_in;                dest = 4'b0001; end
      4'd7:  begin res = X_in + DATA_W'(1);   dest = 4'b0100; end
      4'd8:  begin res = Y_in + DATA_W'(1);   dest = 4'b0010; end
      4'd9:  begin res = X_in - DATA_W'(1);   dest = 4'b0100; end
      4'd10: begin res = Y_in - DATA_W'(1);   dest = 4'b0010; end
      4'd11: begin res = imm_q;               dest = 4'b0100; end
      4'd12: begin res = imm_q;               dest = 4'b0010; end
      4'd13: begin res = imm_q;               dest = 4'b1000; end
      default: begin res = '0;                dest = 4'b0000; end
    endcase
  end

  always_ff @(posedge FSM_Signal or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_q    <= '0;
      imm_q   <= '0;
      bus_out <= '0;
      load_A  <= 1'b0;
      load_X  <= 1'b0;
      load_Y  <= 1'b0;
      load_S  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            op_q  <= op_code;
            imm_q <= op_imm;
            state <= SRC;
          end
        end
        SRC: begin
          if (dest != 4'b0000) bus_out <= res;
          {load_A, load_X, load_Y, load_S} <= dest;
          state <= WR;
        end
        WR: begin
          {load_A, load_X, load_Y, load_S} <= 4'b0000;
          done  <= 1'b1;
          err   <= (op_q >= 4'd14);
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (op_valid) begin
            op_q  <= op_code;
            imm_q <= op_imm;
            state <= SRC;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XFER_FLAGS_EN
  logic writes_flags;

  // Every legal opcode updates N/Z except NOP and TXS.
  assign writes_flags = (op_q != 4'd0) && (op_q != 4'd6) && (op_q <= 4'd13);

  always_ff @(posedge FSM_Signal or negedge reset_n) begin
    if (!reset_n) begin
      flag_N  <= 1'b0;
      flag_Z  <= 1'b0;
      flag_we <= 1'b0;
    end else if (state == WR) begin
      flag_N  <= bus_out[DATA_W-1];
      flag_Z  <= (bus_out == '0);
      flag_we <= writes_flags;
    end else if (state == DONE) begin
      flag_we <= 1'b0;
    end
  end
`else
  assign flag_N  = 1'b0;
  assign flag_Z  = 1'b0;
  assign flag_we = 1'b0;
`endif

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// tb/tb_reg_xfer_ctrl.sv - scoreboard bench for reg_xfer_ctrl
module tb_reg_xfer_ctrl;

`ifdef XFER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic       FSM_Signal = 1'b0;
  logic       reset_n = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] op_code = 4'd0;
  logic [7:0] op_imm = 8'h00;
  logic [7:0] A_in = 8'h80, X_in = 8'hFF, Y_in = 8'h00, S_in = 8'hFD;
  logic [7:0] bus_out;
  logic       load_A, load_X, load_Y, load_S;
  logic       flag_N, flag_Z, flag_we, done, err;

  reg_xfer_ctrl #(.DATA_W(8)) dut (
    .FSM_Signal(FSM_Signal), .reset_n(reset_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_imm(op_imm),
    .A_in(A_in), .X_in(X_in), .Y_in(Y_in), .S_in(S_in),
    .bus_out(bus_out), .load_A(load_A), .load_X(load_X), .load_Y(load_Y), .load_S(load_S),
    .flag_N(flag_N), .flag_Z(flag_Z), .flag_we(flag_we), .done(done), .err(err)
  );

  always #5 FSM_Signal = ~FSM_Signal;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_done = 0;

  always @(posedge FSM_Signal) cyc++;

  typedef struct {
    logic [3:0] ld;
    logic [7:0] bus;
    logic       er, we, n, z, fchk;
    int         acc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: accumulates load activity, checks against the queue head on done.
  exp_t       me;
  int         ld_cnt = 0;
  int         ld_cyc = 0;
  logic [3:0] ld_seen = 4'b0000;
  logic [7:0] bus_seen = 8'h00;

  always @(negedge FSM_Signal) begin
    if (!reset_n) begin
      ld_cnt  = 0;
      ld_seen = 4'b0000;
    end else begin
      if ({load_A, load_X, load_Y, load_S} != 4'b0000) begin
        ld_cnt++;
        ld_seen  = {load_A, load_X, load_Y, load_S};
        ld_cyc   = cyc;
        bus_seen = bus_out;
      end
      if (done) begin
        n_done++;
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          me = q.pop_front();
          chk("loads", 32'(ld_seen), 32'(me.ld));
          chk("load_cycles", 32'(ld_cnt), (me.ld != 4'b0000) ? 32'd1 : 32'd0);
          if (me.ld != 4'b0000) begin
            chk("bus_at_load", 32'(bus_seen), 32'(me.bus));
            chk("load_latency", 32'(ld_cyc), 32'(me.acc + 1));
            chk("bus_at_done", 32'(bus_out), 32'(me.bus));
          end
          chk("done_latency", 32'(cyc), 32'(me.acc + 2));
          chk("err", 32'(err), 32'(me.er));
          chk("flag_we", 32'(flag_we), 32'(FLAGS & me.we));
          if (me.fchk) begin
            chk("flag_N", 32'(flag_N), 32'(FLAGS & me.n));
            chk("flag_Z", 32'(flag_Z), 32'(FLAGS & me.z));
          end
        end
        ld_cnt  = 0;
        ld_seen = 4'b0000;
      end
    end
  end

  task automatic push_exp(input logic [3:0] ld, input logic [7:0] bus,
                          input logic er, we, n, z, fchk, input int acc);
    exp_t e;
    e.ld = ld; e.bus = bus; e.er = er; e.we = we; e.n = n; e.z = z; e.fchk = fchk; e.acc = acc;
    q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] code, input logic [7:0] imm,
                       input logic [3:0] ld, input logic [7:0] bus,
                       input logic er, we, n, z, fchk, input bit push, output int acc);
    int w;
    w = 0;
    acc = -1;
    while (!op_ready && w < 20) begin
      @(negedge FSM_Signal);
      w++;
    end
    if (!op_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    op_valid = 1'b1;
    op_code  = code;
    op_imm   = imm;
    @(posedge FSM_Signal);
    #1;
    acc = cyc;
    if (push) push_exp(ld, bus, er, we, n, z, fchk, acc);
    @(negedge FSM_Signal);
    op_valid = 1'b0;
  endtask

  int a1, a2, nd, w;

  initial begin
    repeat (2) @(posedge FSM_Signal);
    @(negedge FSM_Signal);
    reset_n = 1'b1;
    #1;
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_bus_out", 32'(bus_out), 32'd0);
    chk("rst_loads", 32'({load_A, load_X, load_Y, load_S}), 32'd0);
    chk("rst_flags", 32'({flag_N, flag_Z, flag_we}), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    @(negedge FSM_Signal);

    issue(4'd1, 8'h00, 4'b0100, 8'h80, 0, 1, 1, 0, 1, 1, a1);   // TAX A=80
    repeat (3) @(negedge FSM_Signal);

    issue(4'd7, 8'h00, 4'b0100, 8'h00, 0, 1, 0, 1, 1, 1, a1);   // INX X=FF
    issue(4'd10, 8'h00, 4'b0010, 8'hFF, 0, 1, 1, 0, 1, 1, a2);  // DEY Y=00
    chk("b2b_gap", 32'(a2 - a1), 32'd3);
    repeat (3) @(negedge FSM_Signal);

    X_in = 8'h3C;
    issue(4'd6, 8'h00, 4'b0001, 8'h3C, 0, 0, 0, 0, 1, 1, a1);   // TXS
    issue(4'd15, 8'h00, 4'b0000, 8'h00, 1, 0, 0, 0, 0, 1, a1);  // illegal
    issue(4'd0, 8'h00, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 1, a1);   // NOP
    issue(4'd5, 8'h00, 4'b0100, 8'hFD, 0, 1, 1, 0, 1, 1, a1);   // TSX
    issue(4'd4, 8'h00, 4'b1000, 8'h00, 0, 1, 0, 1, 1, 1, a1);   // TYA
    issue(4'd3, 8'h00, 4'b1000, 8'h3C, 0, 1, 0, 0, 1, 1, a1);   // TXA
    issue(4'd2, 8'h00, 4'b0010, 8'h80, 0, 1, 1, 0, 1, 1, a1);   // TAY
    issue(4'd9, 8'h00, 4'b0100, 8'h3B, 0, 1, 0, 0, 1, 1, a1);   // DEX
    issue(4'd11, 8'h7F, 4'b0100, 8'h7F, 0, 1, 0, 0, 1, 1, a1);  // LDX#
    repeat (4) @(negedge FSM_Signal);

    // op_valid held high; op_code changes while busy.
    op_valid = 1'b1;
    op_code  = 4'd12;
    op_imm   = 8'h42;
    @(posedge FSM_Signal);
    #1;
    a1 = cyc;
    push_exp(4'b0010, 8'h42, 0, 1, 0, 0, 1, a1);
    @(negedge FSM_Signal);
    op_code = 4'd8;
    op_imm  = 8'h99;
    w = 0;
    while (!op_ready && w < 20) begin
      @(negedge FSM_Signal);
      w++;
    end
    @(posedge FSM_Signal);
    #1;
    a2 = cyc;
    push_exp(4'b0010, 8'h01, 0, 1, 0, 0, 1, a2);
    @(negedge FSM_Signal);
    op_valid = 1'b0;
    chk("hold_gap", 32'(a2 - a1), 32'd3);
    repeat (5) @(negedge FSM_Signal);

    // Reset during WR of LDA# 0x55.
    issue(4'd13, 8'h55, 4'b1000, 8'h55, 0, 1, 0, 0, 1, 0, a1);
    @(posedge FSM_Signal);
    #2;
    chk("abort_load_A_in_wr", 32'(load_A), 32'd1);
    nd = n_done;
    reset_n = 1'b0;
    #1;
    chk("abort_load_A", 32'(load_A), 32'd0);
    chk("abort_bus_out", 32'(bus_out), 32'd0);
    chk("abort_op_ready", 32'(op_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge FSM_Signal);
    reset_n = 1'b1;
    repeat (6) @(negedge FSM_Signal);
    chk("no_done_after_abort", 32'(n_done), 32'(nd));

    issue(4'd13, 8'h55, 4'b1000, 8'h55, 0, 1, 0, 0, 1, 1, a1);  // LDA# after abort

    w = 0;
    while (q.size() != 0 && w < 30) begin
      @(negedge FSM_Signal);
      w++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
